// File: rtl/dpram_pkg.sv
// Shared definitions for the parametrised true dual-port RAM: write-mode codes and clear FSM states.
package dpram_pkg;

    localparam int unsigned WM_READ_FIRST  = 0;
    localparam int unsigned WM_WRITE_FIRST = 1;
    localparam int unsigned WM_NO_CHANGE   = 2;

    typedef enum logic {
        StIdle,
        StClear
    } clr_state_e;

endpackage

// File: rtl/dpram_out_pipe.sv
// Per-port read output pipeline: stage1/dout registers, stage-valid tracking and valid generation
// for a read latency of 1 or 2.
module dpram_out_pipe #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic              oce_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              valid_o
);

    logic [DATA_W-1:0] stage1_q, stage1_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              svalid_q, svalid_d;
    logic              valid_q, valid_d;

    always_comb begin
        stage1_d = stage1_q;
        svalid_d = svalid_q;
        dout_d   = dout_q;
        valid_d  = 1'b0;
        if (READ_LATENCY == 1) begin
            // Single register: the read lands straight in dout.
            if (load_i) begin
                dout_d = rdata_i;
            end
            valid_d = load_i;
        end else begin
            if (load_i) begin
                stage1_d = rdata_i;
            end
            if (oce_i) begin
                dout_d  = stage1_q;
                valid_d = svalid_q;
            end
            // A new access re-arms the stage even when the old one drains this cycle.
            if (load_i) begin
                svalid_d = 1'b1;
            end else if (oce_i) begin
                svalid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stage1_q <= '0;
            svalid_q <= 1'b0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            stage1_q <= stage1_d;
            svalid_q <= svalid_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
        end
    end

    assign dout_o  = dout_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/dpram_tdp_param.sv
// Single-clock true dual-port RAM with byte enables, selectable read latency, per-port write mode,
// cross-port collision flag and an optional zeroing sweep after reset.
module dpram_tdp_param
    import dpram_pkg::*;
#(
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned BYTE_W         = 8,
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned WRITE_MODE     = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     busy,
    input  logic                     cea,
    input  logic                     ceb,
    input  logic                     ocea,
    input  logic                     oceb,
    input  logic [DATA_W/BYTE_W-1:0] wea,
    input  logic [DATA_W/BYTE_W-1:0] web,
    input  logic [ADDR_W-1:0]        ada,
    input  logic [ADDR_W-1:0]        adb,
    input  logic [DATA_W-1:0]        dina,
    input  logic [DATA_W-1:0]        dinb,
    output logic [DATA_W-1:0]        douta,
    output logic [DATA_W-1:0]        doutb,
    output logic                     valida,
    output logic                     validb,
    output logic                     collision
);

    localparam int unsigned NB    = DATA_W / BYTE_W;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    if (DATA_W % BYTE_W != 0) begin : g_bad_byte_w
        $error("DATA_W must be a multiple of BYTE_W");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end
    if (WRITE_MODE > WM_NO_CHANGE) begin : g_bad_mode
        $error("WRITE_MODE must be 0, 1 or 2");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    clr_state_e        state_q;
    logic [ADDR_W-1:0] clr_addr_q;
    logic              collision_q;

    logic              ce_a, ce_b, wr_a, wr_b, load_a, load_b, clr_we;
    logic [DATA_W-1:0] old_a, old_b, new_a, new_b, rdata_a, rdata_b;

    assign busy   = (state_q == StClear);
    assign clr_we = busy & ~reset;
    assign ce_a   = cea & ~busy & ~reset;
    assign ce_b   = ceb & ~busy & ~reset;
    assign wr_a   = ce_a & (|wea);
    assign wr_b   = ce_b & (|web);

    always_comb begin
        old_a = mem_q[ada];
        old_b = mem_q[adb];
        new_a = old_a;
        new_b = old_b;
        for (int unsigned i = 0; i < NB; i++) begin
            if (wea[i]) new_a[i*BYTE_W +: BYTE_W] = dina[i*BYTE_W +: BYTE_W];
            if (web[i]) new_b[i*BYTE_W +: BYTE_W] = dinb[i*BYTE_W +: BYTE_W];
        end
        // Only a port's own write is forwarded; the other port always sees the old word.
        rdata_a = (WRITE_MODE == WM_WRITE_FIRST) ? new_a : old_a;
        rdata_b = (WRITE_MODE == WM_WRITE_FIRST) ? new_b : old_b;
        load_a  = ce_a & ~((WRITE_MODE == WM_NO_CHANGE) & wr_a);
        load_b  = ce_b & ~((WRITE_MODE == WM_NO_CHANGE) & wr_b);
    end

    // Port A bytes are applied after port B so A wins same-byte conflicts.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr_q] <= '0;
        end else begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (ce_b && web[i]) mem_q[adb][i*BYTE_W +: BYTE_W] <= dinb[i*BYTE_W +: BYTE_W];
            end
            for (int unsigned i = 0; i < NB; i++) begin
                if (ce_a && wea[i]) mem_q[ada][i*BYTE_W +: BYTE_W] <= dina[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? StClear : StIdle;
            clr_addr_q  <= '0;
            collision_q <= 1'b0;
        end else begin
            collision_q <= ce_a & ce_b & (ada == adb) & (wr_a | wr_b);
            unique case (state_q)
                StClear: begin
                    clr_addr_q <= clr_addr_q + 1'b1;
                    if (clr_addr_q == '1) state_q <= StIdle;
                end
                StIdle: begin
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign collision = collision_q;

    dpram_out_pipe #(
        .DATA_W      (DATA_W),
        .READ_LATENCY(READ_LATENCY)
    ) u_pipe_a (
        .clk_i  (clk),
        .reset_i(reset),
        .load_i (load_a),
        .oce_i  (ocea),
        .rdata_i(rdata_a),
        .dout_o (douta),
        .valid_o(valida)
    );

    dpram_out_pipe #(
        .DATA_W      (DATA_W),
        .READ_LATENCY(READ_LATENCY)
    ) u_pipe_b (
        .clk_i  (clk),
        .reset_i(reset),
        .load_i (load_b),
        .oce_i  (oceb),
        .rdata_i(rdata_b),
        .dout_o (doutb),
        .valid_o(validb)
    );

endmodule

// File: tb/tb_dpram_tdp_param.sv
// Directed scoreboard bench: four RAM variants (RF, WF, NC at latency 1; RF at latency 2) share stimulus.
module tb_dpram_tdp_param;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cea, ceb, ocea, oceb;
    logic [1:0]  wea, web;
    logic [3:0]  ada, adb;
    logic [15:0] dina, dinb;

    logic        rf_busy, wf_busy, nc_busy, l2_busy;
    logic [15:0] rf_douta, wf_douta, nc_douta, l2_douta;
    logic [15:0] rf_doutb, wf_doutb, nc_doutb, l2_doutb;
    logic        rf_valida, wf_valida, nc_valida, l2_valida;
    logic        rf_validb, wf_validb, nc_validb, l2_validb;
    logic        rf_coll, wf_coll, nc_coll, l2_coll;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dpram_tdp_param #(.ADDR_W(4), .READ_LATENCY(1), .WRITE_MODE(0), .CLEAR_ON_RESET(1)) u_rf (
        .clk(clk), .reset(reset), .busy(rf_busy), .cea(cea), .ceb(ceb), .ocea(ocea), .oceb(oceb),
        .wea(wea), .web(web), .ada(ada), .adb(adb), .dina(dina), .dinb(dinb),
        .douta(rf_douta), .doutb(rf_doutb), .valida(rf_valida), .validb(rf_validb),
        .collision(rf_coll)
    );
    dpram_tdp_param #(.ADDR_W(4), .READ_LATENCY(1), .WRITE_MODE(1), .CLEAR_ON_RESET(1)) u_wf (
        .clk(clk), .reset(reset), .busy(wf_busy), .cea(cea), .ceb(ceb), .ocea(ocea), .oceb(oceb),
        .wea(wea), .web(web), .ada(ada), .adb(adb), .dina(dina), .dinb(dinb),
        .douta(wf_douta), .doutb(wf_doutb), .valida(wf_valida), .validb(wf_validb),
        .collision(wf_coll)
    );
    dpram_tdp_param #(.ADDR_W(4), .READ_LATENCY(1), .WRITE_MODE(2), .CLEAR_ON_RESET(1)) u_nc (
        .clk(clk), .reset(reset), .busy(nc_busy), .cea(cea), .ceb(ceb), .ocea(ocea), .oceb(oceb),
        .wea(wea), .web(web), .ada(ada), .adb(adb), .dina(dina), .dinb(dinb),
        .douta(nc_douta), .doutb(nc_doutb), .valida(nc_valida), .validb(nc_validb),
        .collision(nc_coll)
    );
    dpram_tdp_param #(.ADDR_W(4), .READ_LATENCY(2), .WRITE_MODE(0), .CLEAR_ON_RESET(1)) u_l2 (
        .clk(clk), .reset(reset), .busy(l2_busy), .cea(cea), .ceb(ceb), .ocea(ocea), .oceb(oceb),
        .wea(wea), .web(web), .ada(ada), .adb(adb), .dina(dina), .dinb(dinb),
        .douta(l2_douta), .doutb(l2_doutb), .valida(l2_valida), .validb(l2_validb),
        .collision(l2_coll)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];

    function automatic logic [15:0] obs(input int sel);
        case (sel)
            0:       return rf_douta;
            1:       return {15'd0, rf_valida};
            2:       return wf_douta;
            3:       return nc_douta;
            4:       return {15'd0, nc_valida};
            5:       return l2_douta;
            6:       return {15'd0, l2_valida};
            7:       return rf_doutb;
            8:       return {15'd0, rf_coll};
            9:       return {15'd0, rf_busy};
            10:      return {15'd0, wf_valida};
            default: return 16'hxxxx;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [15:0] e);
        exp_t x;
        x.tag = tag;
        x.sel = sel;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic tick();
        exp_t x;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            chk(x.tag, obs(x.sel), x.exp);
        end
    endtask

    task automatic idle();
        cea = 1'b0; ceb = 1'b0; ocea = 1'b0; oceb = 1'b0;
        wea = 2'b00; web = 2'b00;
    endtask

    task automatic op_a(input logic [3:0] a, input logic [15:0] d, input logic [1:0] we);
        cea = 1'b1; ada = a; dina = d; wea = we;
    endtask

    task automatic op_b(input logic [3:0] a, input logic [15:0] d, input logic [1:0] we);
        ceb = 1'b1; adb = a; dinb = d; web = we;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        idle();
        ada = '0; adb = '0; dina = '0; dinb = '0;

        // Reset phase: outputs quiet, sweep armed.
        tick();
        push("rst_busy", 9, 16'd1);
        push("rst_douta", 0, 16'd0);
        push("rst_valida", 1, 16'd0);
        push("rst_coll", 8, 16'd0);
        push("rst_l2_douta", 5, 16'd0);
        tick();

        reset = 1'b0;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (!rf_busy) break;
        end
        chk("clear_cycles", 16'(n), 16'd16);

        for (int i = 0; i < 16; i++) begin
            op_a(4'(i), 16'h0, 2'b00);
            push("clr_rd", 0, 16'h0000);
            push("clr_rv", 1, 16'd1);
            tick();
        end
        idle();

        // Byte-enable merge.
        op_a(4'd3, 16'hBEEF, 2'b11);
        tick();
        op_a(4'd3, 16'h1234, 2'b01);
        tick();
        op_a(4'd3, 16'h0, 2'b00);
        push("byte_rd", 0, 16'hBE34);
        push("byte_rv", 1, 16'd1);
        tick();
        idle();
        push("idle_rv", 1, 16'd0);
        push("nc_after_rd", 3, 16'hBE34);
        tick();

        // Same-port write modes.
        op_a(4'd5, 16'hAAAA, 2'b11);
        push("nc_wr_valid", 4, 16'd0);
        push("wf_first", 2, 16'hAAAA);
        tick();
        op_a(4'd5, 16'h5555, 2'b11);
        push("rf_old", 0, 16'hAAAA);
        push("rf_wr_valid", 1, 16'd1);
        push("wf_new", 2, 16'h5555);
        push("wf_wr_valid", 10, 16'd1);
        push("nc_hold", 3, 16'hBE34);
        push("nc_valid0", 4, 16'd0);
        tick();

        // Latency 2: stage holds until ocea.
        op_a(4'd5, 16'h0, 2'b00);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            push("l2_stall_dout", 5, 16'h0000);
            push("l2_stall_valid", 6, 16'd0);
            tick();
        end
        ocea = 1'b1;
        push("l2_dout", 5, 16'h5555);
        push("l2_valid", 6, 16'd1);
        tick();
        push("l2_valid_once", 6, 16'd0);
        push("l2_dout_keep", 5, 16'h5555);
        tick();
        idle();

        // Cross-port collisions.
        op_a(4'd7, 16'h1111, 2'b11);
        op_b(4'd7, 16'h2222, 2'b11);
        push("coll_ww", 8, 16'd1);
        tick();
        op_a(4'd7, 16'h0, 2'b00);
        op_b(4'd7, 16'h0, 2'b00);
        push("coll_rr", 8, 16'd0);
        push("a_wins", 0, 16'h1111);
        push("a_wins_b", 7, 16'h1111);
        tick();
        op_a(4'd7, 16'h3333, 2'b11);
        op_b(4'd7, 16'h0, 2'b00);
        push("coll_wr", 8, 16'd1);
        push("b_sees_old", 7, 16'h1111);
        tick();
        op_a(4'd7, 16'h00AA, 2'b01);
        op_b(4'd7, 16'h2222, 2'b11);
        push("rf_a_read", 0, 16'h3333);
        tick();
        idle();
        op_a(4'd7, 16'h0, 2'b00);
        push("byte_coll", 0, 16'h22AA);
        push("coll_clear", 8, 16'd0);
        tick();
        idle();

        // Reset mid-sweep restarts it; accesses while busy are ignored.
        reset = 1'b1;
        push("rst2_busy", 9, 16'd1);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        op_a(4'd0, 16'hFFFF, 2'b11);
        n = 0;
        while (n < 40) begin
            push("busy_no_valid", 1, 16'd0);
            tick();
            n++;
            if (!rf_busy) break;
        end
        chk("restart_cycles", 16'(n), 16'd16);
        op_a(4'd0, 16'h0, 2'b00);
        push("busy_wr_ignored", 0, 16'h0000);
        tick();
        op_a(4'd3, 16'h0, 2'b00);
        push("recleared", 0, 16'h0000);
        push("recleared_v", 1, 16'd1);
        tick();
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
